// File: rtl/mod_mul_chk_pkg.sv
// Shared definitions for the sequential modular multiplier/check block.
package mod_mul_chk_pkg;

  localparam int IP_WIDTH_DEF = 6;
  localparam int MOD_MIN      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod_mul_chk_step.sv
// One interleaved step: (2*acc mod M), then optionally (+A mod M).
module mod_add_sub_step #(
  parameter int IP_WIDTH = 6
) (
  input  logic [IP_WIDTH-1:0] i_acc,
  input  logic [IP_WIDTH-1:0] i_a,
  input  logic [IP_WIDTH-1:0] i_mod,
  input  logic                i_bit,
  output logic [IP_WIDTH-1:0] o_acc
);

  logic [IP_WIDTH:0] w_mod_ext;
  logic [IP_WIDTH:0] w_dbl;
  logic [IP_WIDTH:0] w_dbl_red;
  logic [IP_WIDTH:0] w_sum;
  logic [IP_WIDTH:0] w_sum_red;

  // acc < M and A < M keep both intermediates below 2M, so one extra bit suffices
  always_comb begin
    w_mod_ext = {1'b0, i_mod};
    w_dbl     = {i_acc, 1'b0};
    if (w_dbl >= w_mod_ext) begin
      w_dbl_red = w_dbl - w_mod_ext;
    end else begin
      w_dbl_red = w_dbl;
    end
    w_sum = w_dbl_red + {1'b0, i_a};
    if (w_sum >= w_mod_ext) begin
      w_sum_red = w_sum - w_mod_ext;
    end else begin
      w_sum_red = w_sum;
    end
    if (i_bit) begin
      o_acc = w_sum_red[IP_WIDTH-1:0];
    end else begin
      o_acc = w_dbl_red[IP_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mod_mul_chk.sv
// Sequential (A*B) mod M, MSB-first shift-add, with modular-inverse flag.
module mod_mul_chk
  import mod_mul_chk_pkg::*;
#(
  parameter int IP_WIDTH = IP_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [IP_WIDTH-1:0] IN_A,
  input  logic [IP_WIDTH-1:0] IN_B,
  input  logic [IP_WIDTH-1:0] IN_MOD,
  output logic                busy,
  output logic                out_valid,
  output logic [IP_WIDTH-1:0] OUT_PROD,
  output logic                OUT_IS_INV,
  output logic                OUT_ERR
);

  localparam int CW = (IP_WIDTH > 2) ? $clog2(IP_WIDTH) : 1;

  state_t              r_state;
  logic [IP_WIDTH-1:0] r_acc;
  logic [CW-1:0]       r_cnt;
  logic [IP_WIDTH-1:0] r_a;
  logic [IP_WIDTH-1:0] r_b;
  logic [IP_WIDTH-1:0] r_mod;
  logic                r_err;
  logic                r_out_valid;
  logic [IP_WIDTH-1:0] r_prod;
  logic                r_is_inv;
  logic                r_err_out;

  logic                w_legal;
  logic [IP_WIDTH-1:0] w_next;

  assign w_legal = (IN_MOD >= IP_WIDTH'(MOD_MIN)) && (IN_A < IN_MOD) && (IN_B < IN_MOD);

  mod_add_sub_step #(.IP_WIDTH(IP_WIDTH)) u_step (
    .i_acc (r_acc),
    .i_a   (r_a),
    .i_mod (r_mod),
    .i_bit (r_b[r_cnt]),
    .o_acc (w_next)
  );

  // Control FSM, datapath registers and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_mod       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_prod      <= '0;
      r_is_inv    <= 1'b0;
      r_err_out   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_out_valid <= 1'b0;
          r_prod      <= '0;
          r_is_inv    <= 1'b0;
          r_err_out   <= 1'b0;
          if (in_valid) begin
            r_a   <= IN_A;
            r_b   <= IN_B;
            r_mod <= IN_MOD;
            r_acc <= '0;
            if (w_legal) begin
              r_cnt   <= CW'(IP_WIDTH - 1);
              r_err   <= 1'b0;
              r_state <= ST_CALC;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          r_acc <= w_next;
          if (r_cnt == '0) begin
            r_out_valid <= 1'b1;
            r_prod      <= w_next;
            r_is_inv    <= (w_next == IP_WIDTH'(1));
            r_err_out   <= 1'b0;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DONE: begin
          // Error path enters DONE without a strobe; it is raised one edge later
          if (r_err && !r_out_valid) begin
            r_out_valid <= 1'b1;
            r_prod      <= '0;
            r_is_inv    <= 1'b0;
            r_err_out   <= 1'b1;
          end else begin
            r_out_valid <= 1'b0;
            r_prod      <= '0;
            r_is_inv    <= 1'b0;
            r_err_out   <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_prod      <= '0;
          r_is_inv    <= 1'b0;
          r_err_out   <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign out_valid  = r_out_valid;
  assign OUT_PROD   = r_prod;
  assign OUT_IS_INV = r_is_inv;
  assign OUT_ERR    = r_err_out;

endmodule

// File: doc/mod_mul_chk.md
Name: mod_mul_chk

Overview:
- Sequential modular multiplier, the check-direction counterpart of the team's modular-inverse IP.
- Computes P = (A*B) mod M with an interleaved shift-add (MSB-first), one multiplier bit per cycle.
- Flags whether B is the modular inverse of A, i.e. P == 1.
- Used behind the inverse stage to verify or consume its result, e.g. modular division a*b^-1.

Parameters:
- IP_WIDTH, 6, operand/modulus width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  one-cycle strobe; IN_A/IN_B/IN_MOD valid this cycle
- IN_A  input  IP_WIDTH  multiplicand
- IN_B  input  IP_WIDTH  multiplier (scanned MSB first)
- IN_MOD  input  IP_WIDTH  modulus M
- busy  output  1  high whenever state != IDLE
- out_valid  output  1  one-cycle result strobe
- OUT_PROD  output  IP_WIDTH  (A*B) mod M; 0 when out_valid low
- OUT_IS_INV  output  1  OUT_PROD == 1; 0 when out_valid low
- OUT_ERR  output  1  illegal operands; 0 when out_valid low

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, bit counter=0, captured operands=0. busy, out_valid, OUT_PROD, OUT_IS_INV and OUT_ERR all = 0.
- States: IDLE, CALC, DONE.
- IDLE, in_valid=1 at edge E0:
  - Capture A, B, M.
  - Legal operands (M>=2, A<M, B<M): acc<=0, cnt<=IP_WIDTH-1, go to CALC.
  - Illegal operands: go directly to DONE with err=1, product=0.
- in_valid when state != IDLE: ignored, not queued. No back-pressure beyond busy.
- CALC, each edge, with k = cnt:
  - d = 2*acc (IP_WIDTH+1 bits); if d>=M then d=d-M.
  - If B[k]=1: s = d+A (IP_WIDTH+1 bits); if s>=M then s=s-M; acc<=s. Otherwise acc<=d.
  - If cnt==0, go to DONE; otherwise cnt<=cnt-1.
  - Invariant: acc<M after every step. Only one conditional subtract per add.
- DONE (one cycle): out_valid=1, OUT_PROD=acc (0 if err), OUT_IS_INV=(acc==1 && !err), OUT_ERR=err. Next edge goes to IDLE.
- Outputs are driven from registered state/acc, with no combinational path from inputs.
- Latency:
  - Legal: out_valid is high in the cycle after edge E0+IP_WIDTH, i.e. IP_WIDTH+1 edges after sampling.
  - Error: out_valid is high in the cycle after E0+1.
- Throughput: a new in_valid is accepted in the cycle after out_valid at the earliest; in_valid during the DONE cycle is ignored.
- A=0 or B=0 gives OUT_PROD=0, OUT_IS_INV=0, OUT_ERR=0.
- M at its maximum (2^IP_WIDTH-1) must not overflow; this is why the IP_WIDTH+1 intermediates are required.
- rst asserted mid-CALC: immediate return to the reset values. No out_valid for the aborted operation.

Decomposition:
- Shared package:
  - state enum (IDLE/CALC/DONE)
  - IP_WIDTH default
  - MOD_MIN=2 constant
- One natural sub-module, mod_add_sub_step: combinational "2*acc mod M, then +A mod M" datapath, parameterised by IP_WIDTH. The top holds the FSM, counter and registers.

Test Plan:
1. Reset then idle: rst=1 mid-stream. All outputs read 0 immediately (asynchronously); busy=0 after release.
2. IP_WIDTH=6, A=5, B=12, M=59 -> out_valid exactly 7 edges after sampling, OUT_PROD=1, OUT_IS_INV=1, OUT_ERR=0.
3. A=7, B=9, M=13 -> OUT_PROD=11, OUT_IS_INV=0; A=0, B=9, M=13 -> OUT_PROD=0.
4. Max modulus: A=62, B=62, M=63 -> OUT_PROD=1, OUT_IS_INV=1, no overflow. Exhaustive sweep over all legal (A,B,M) compared with a reference model.
5. Illegal operands:
   - M=1 -> OUT_ERR=1, OUT_PROD=0 with out_valid after 2 edges.
   - A=20, B=3, M=13 -> OUT_ERR=1.
6. Protocol:
   - Second in_valid pulsed during CALC and during DONE -> ignored; exactly one out_valid with the first result.
   - rst pulsed at CALC cycle 3 -> no out_valid.
   - Next legal op after reset completes correctly.
